arima_seq_ctrl: RTL and testbench

Parametrised sequencer for the ARIMA datapath. It drives the difference, AR, MA and integration stages through an initialisation phase sized by the configured (p,d,q) orders, then through a bounded or free-running forecast loop. It generates sample-memory read/write addresses and strobes. Compared with the current top-level FSM it adds:
- order range checking
- MA-aware initialisation length
- step counting with completion
- abort
- downstream stall

---
 rtl/arima_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_arima_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arima_seq_ctrl.sv
// Sequencer for the ARIMA datapath: order-checked initialisation, then a bounded
// or free-running 4-cycle forecast loop with abort, stall and memory addressing.
module arima_seq_ctrl #(
    parameter int unsigned N         = 32,
    parameter int unsigned MAX_ORDER = 16,
    parameter int unsigned WR_OFFSET = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] p_order,
    input  logic [N-1:0] d_order,
    input  logic [N-1:0] q_order,
    input  logic [N-1:0] num_steps,
    input  logic         abort,
    input  logic         stall,
    output logic [1:0]   c_diff,
    output logic [1:0]   c_ar,
    output logic [1:0]   c_ma,
    output logic [1:0]   c_inte,
    output logic         sel_inte_in,
    output logic         init_mode,
    output logic         ready,
    output logic         rden,
    output logic         wren,
    output logic [N-1:0] address_r,
    output logic [N-1:0] address_w,
    output logic [N-1:0] current_time_step,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_INIT_DIFF, S_INIT_INTE, S_INIT_ARMA, S_FLUSH,
        S_READY, S_WORK_DIFF, S_WORK_ARMA, S_WORK_INTE, S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] ord_q [3];
    logic [N-1:0] ord_d [3];
    logic [N-1:0] steps_q, steps_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] step_cnt_q, step_cnt_d;
    logic [N-1:0] phase_q, phase_d;
    logic         cfg_err_q, cfg_err_d;

    logic [2:0]   order_bad;
    logic [N-1:0] diff_len, pq_max, arma_len, step_next;
    logic         in_loop, loop_stall;

    // ord_q[0]=p, ord_q[1]=d, ord_q[2]=q
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_range
            assign order_bad[gi] = (ord_q[gi] > N'(MAX_ORDER));
        end
    endgenerate

    assign diff_len   = (ord_q[1] == '0) ? N'(1) : ord_q[1];
    assign pq_max     = (ord_q[0] > ord_q[2]) ? ord_q[0] : ord_q[2];
    assign arma_len   = (pq_max == '0) ? N'(1) : pq_max;
    assign step_next  = step_cnt_q + N'(1);
    assign in_loop    = state_q inside {S_READY, S_WORK_DIFF, S_WORK_ARMA, S_WORK_INTE};
    assign loop_stall = stall && in_loop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ord_q      <= '{default: '0};
            steps_q    <= '0;
            addr_q     <= '0;
            step_cnt_q <= '0;
            phase_q    <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ord_q      <= ord_d;
            steps_q    <= steps_d;
            addr_q     <= addr_d;
            step_cnt_q <= step_cnt_d;
            phase_q    <= phase_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ord_d      = ord_q;
        steps_d    = steps_q;
        addr_d     = addr_q;
        step_cnt_d = step_cnt_q;
        phase_d    = phase_q;
        cfg_err_d  = cfg_err_q;

        if ((state_q inside {S_INIT_DIFF, S_INIT_INTE, S_INIT_ARMA}) ||
            (state_q == S_READY && !stall))
            addr_d = addr_q + N'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CHECK;
                    ord_d[0]   = p_order;
                    ord_d[1]   = d_order;
                    ord_d[2]   = q_order;
                    steps_d    = num_steps;
                    addr_d     = '0;
                    step_cnt_d = '0;
                    cfg_err_d  = 1'b0;
                end
            end
            S_CHECK: begin
                if (|order_bad) begin
                    state_d   = S_DONE;
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = S_INIT_DIFF;
                end
            end
            S_INIT_DIFF: begin
                if (phase_q == diff_len - N'(1)) begin
                    state_d = S_INIT_INTE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + N'(1);
                end
            end
            S_INIT_INTE: state_d = S_INIT_ARMA;
            S_INIT_ARMA: begin
                if (phase_q == arma_len - N'(1)) begin
                    state_d = S_FLUSH;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + N'(1);
                end
            end
            S_FLUSH: begin
                if (phase_q == N'(1)) begin
                    state_d = S_READY;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + N'(1);
                end
            end
            S_READY:     if (!stall) state_d = S_WORK_DIFF;
            S_WORK_DIFF: if (!stall) state_d = S_WORK_ARMA;
            S_WORK_ARMA: if (!stall) state_d = S_WORK_INTE;
            S_WORK_INTE: begin
                if (!stall) begin
                    step_cnt_d = step_next;
                    // num_steps of zero never matches: free-running until abort
                    if (steps_q != '0 && step_next == steps_q)
                        state_d = S_DONE;
                    else
                        state_d = S_READY;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d    = S_DONE;
            step_cnt_d = step_cnt_q;
            phase_d    = '0;
        end
    end

    always_comb begin
        {c_diff, c_ar, c_ma, c_inte} = 8'hFF;
        rden        = 1'b0;
        wren        = 1'b0;
        ready       = 1'b0;
        sel_inte_in = 1'b1;
        init_mode   = 1'b1;
        if (state_q == S_FLUSH || in_loop)
            {c_diff, c_ar, c_ma, c_inte} = 8'h55;

        case (state_q)
            S_INIT_DIFF: begin
                c_diff = 2'b00;
                rden   = 1'b1;
            end
            S_INIT_INTE: begin
                c_diff = 2'b00;
                c_inte = 2'b10;
                rden   = 1'b1;
            end
            S_INIT_ARMA: begin
                c_diff = 2'b00;
                c_ar   = 2'b00;
                c_ma   = (ord_q[2] != '0) ? 2'b00 : 2'b11;
                c_inte = 2'b00;
                rden   = 1'b1;
                wren   = 1'b1;
            end
            S_FLUSH: begin
                ready  = 1'b1;
                wren   = 1'b1;
                c_inte = 2'b00;
                if (phase_q == '0) begin
                    c_ar = 2'b00;
                    c_ma = 2'b00;
                    rden = 1'b1;
                end else begin
                    sel_inte_in = 1'b0;
                    init_mode   = 1'b0;
                end
            end
            S_READY: begin
                ready       = 1'b1;
                sel_inte_in = 1'b0;
                init_mode   = 1'b0;
            end
            S_WORK_DIFF: begin
                c_diff      = 2'b00;
                rden        = 1'b1;
                sel_inte_in = 1'b0;
                init_mode   = 1'b0;
            end
            S_WORK_ARMA: begin
                c_ar        = 2'b00;
                c_ma        = 2'b00;
                wren        = 1'b1;
                sel_inte_in = 1'b0;
                init_mode   = 1'b0;
            end
            S_WORK_INTE: begin
                c_inte      = 2'b00;
                sel_inte_in = 1'b0;
                init_mode   = 1'b0;
            end
            default: ;
        endcase

        if (loop_stall) begin
            rden = 1'b0;
            wren = 1'b0;
        end
    end

    assign address_r         = addr_q;
    assign address_w         = addr_q + N'(WR_OFFSET);
    assign current_time_step = addr_q - N'(2);
    assign busy              = (state_q != S_IDLE);
    assign done              = (state_q == S_DONE);
    assign cfg_err           = cfg_err_q;

endmodule

// File: tb/tb_arima_seq_ctrl.sv
// Self-checking bench: a cycle-list model built from the phase lengths and
// per-phase output tables is compared record-by-record against the sequencer.
module tb_arima_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort, stall;
    logic [31:0] p_order, d_order, q_order, num_steps;
    logic [1:0]  c_diff, c_ar, c_ma, c_inte;
    logic        sel_inte_in, init_mode, ready, rden, wren, busy, done, cfg_err;
    logic [31:0] address_r, address_w, current_time_step;

    arima_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .p_order(p_order), .d_order(d_order), .q_order(q_order),
        .num_steps(num_steps), .abort(abort), .stall(stall),
        .c_diff(c_diff), .c_ar(c_ar), .c_ma(c_ma), .c_inte(c_inte),
        .sel_inte_in(sel_inte_in), .init_mode(init_mode), .ready(ready),
        .rden(rden), .wren(wren), .address_r(address_r), .address_w(address_w),
        .current_time_step(current_time_step), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // flags = {sel_inte_in, init_mode, ready, rden, wren, busy, done, cfg_err}
    typedef struct packed {
        logic [7:0]  codes;
        logic [7:0]  flags;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    bit          stall_pat [0:1023];
    logic [31:0] m_addr;
    bit          m_err;
    int          tests_run = 0;
    int          tests_failed = 0;

    function automatic logic [111:0] observed();
        return {c_diff, c_ar, c_ma, c_inte, sel_inte_in, init_mode, ready, rden,
                wren, busy, done, cfg_err, address_r, address_w, current_time_step};
    endfunction

    function automatic logic [111:0] expected(input exp_t e);
        return {e.codes, e.flags, e.addr, e.addr + 32'd1000, e.addr - 32'd2};
    endfunction

    function automatic void push(input logic [7:0] c, input logic [7:0] f);
        exp_t e;
        e.codes = c;
        e.flags = {f[7:1], m_err};
        e.addr  = m_addr;
        exp_q.push_back(e);
    endfunction

    // Expected list of per-cycle outputs, starting with the CHECK cycle.
    function automatic void build(input int unsigned p, d, q, steps, input int abort_rec);
        int unsigned dl, al;
        logic [7:0]  lc [4];
        logic [7:0]  lf [4];
        bit          stop;
        lc = '{8'h55, 8'b00_01_01_01, 8'b01_00_00_01, 8'b01_01_01_00};
        lf = '{8'b0010_0100, 8'b0001_0100, 8'b0000_1100, 8'b0000_0100};
        exp_q.delete();
        m_addr = 0;
        m_err  = 0;
        push(8'hFF, 8'b1100_0100);
        if (p > 16 || d > 16 || q > 16) begin
            m_err = 1;
            push(8'hFF, 8'b1100_0110);
            push(8'hFF, 8'b1100_0000);
            return;
        end
        dl = (d == 0) ? 1 : d;
        al = (p > q) ? p : q;
        if (al == 0) al = 1;
        repeat (dl) begin push(8'b00_11_11_11, 8'b1101_0100); m_addr++; end
        push(8'b00_11_11_10, 8'b1101_0100); m_addr++;
        repeat (al) begin
            push({4'b0000, (q > 0) ? 2'b00 : 2'b11, 2'b00}, 8'b1101_1100);
            m_addr++;
        end
        push(8'b01_00_00_00, 8'b1111_1100);
        push(8'b01_01_01_00, 8'b0010_1100);
        stop = 0;
        for (int unsigned s = 0; !stop && (steps == 0 || s < steps); s++) begin
            for (int ph = 0; ph < 4 && !stop; ph++) begin
                while (stall_pat[exp_q.size()] && exp_q.size() < 1000)
                    push(lc[ph], lf[ph] & 8'b1110_0111);
                push(lc[ph], lf[ph]);
                if (ph == 0) m_addr++;
                if (exp_q.size() - 1 == abort_rec || exp_q.size() >= 1000) stop = 1;
            end
        end
        push(8'hFF, 8'b1100_0110);
        push(8'hFF, 8'b1100_0000);
    endfunction

    task automatic clear_stall();
        foreach (stall_pat[i]) stall_pat[i] = 0;
    endtask

    task automatic run_model(input int unsigned p, d, q, steps, input int abort_rec,
                             input bit noise, output int done_idx, output logic [31:0] done_addr);
        logic [111:0] act, expv;
        build(p, d, q, steps, abort_rec);
        @(negedge clk);
        p_order = p; d_order = d; q_order = q; num_steps = steps; start = 1;
        @(posedge clk); #1;
        start = 0;
        done_idx = -1;
        done_addr = '1;
        for (int k = 0; k < exp_q.size(); k++) begin
            stall = stall_pat[k];
            abort = (k == abort_rec);
            if (noise && k + 1 < exp_q.size()) begin
                start   = 1'($urandom_range(0, 1));
                p_order = $urandom; d_order = $urandom;
                q_order = $urandom; num_steps = $urandom;
            end else begin
                start = 0;
            end
            @(negedge clk);
            act  = observed();
            expv = expected(exp_q[k]);
            tests_run++;
            if (act !== expv) begin
                tests_failed++;
                $display("FAIL rec%0d (p=%0d d=%0d q=%0d n=%0d): got %h expected %h",
                         k, p, d, q, steps, act, expv);
            end
            if (done === 1'b1) begin done_idx = k; done_addr = address_r; end
            @(posedge clk); #1;
        end
        start = 0; stall = 0; abort = 0;
    endtask

    task automatic test_reset();
        logic [111:0] idle_v;
        idle_v = {8'hFF, 8'b1100_0000, 32'd0, 32'd1000, 32'hFFFF_FFFE};
        reset = 1; start = 0; abort = 0; stall = 0;
        p_order = 0; d_order = 0; q_order = 0; num_steps = 0;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (observed() !== idle_v) begin
                tests_failed++;
                $display("FAIL reset_state: got %h expected %h", observed(), idle_v);
            end
        end
        reset = 0;
        $display("[TB] test_reset complete");
    endtask

    task automatic test_basic();
        int di; logic [31:0] da;
        clear_stall();
        run_model(2, 1, 1, 3, -1, 0, di, da);
        tests_run++;
        if (di !== 19 || da !== 32'd7) begin
            tests_failed++;
            $display("FAIL basic_done: got idx %0d addr %0d expected idx 19 addr 7", di, da);
        end
        $display("[TB] test_basic p=2 d=1 q=1 n=3 done_idx=%0d", di);
    endtask

    task automatic test_zero_orders();
        int di; logic [31:0] da;
        clear_stall();
        run_model(0, 0, 0, 1, -1, 0, di, da);
        tests_run++;
        if (di !== 10) begin
            tests_failed++;
            $display("FAIL zero_orders_done: got idx %0d expected 10", di);
        end
        $display("[TB] test_zero_orders done_idx=%0d", di);
    endtask

    task automatic test_cfg_err();
        int di; logic [31:0] da;
        clear_stall();
        run_model(17, 1, 1, 2, -1, 0, di, da);
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_err_sticky: got err %b busy %b expected err 1 busy 0", cfg_err, busy);
            end
        end
        run_model(1, 1, 1, 1, -1, 0, di, da);
        $display("[TB] test_cfg_err complete");
    endtask

    task automatic test_abort();
        int di; logic [31:0] da;
        clear_stall();
        run_model(1, 2, 3, 0, 31, 0, di, da);
        tests_run++;
        if (di !== 32 || da !== 32'd12) begin
            tests_failed++;
            $display("FAIL abort_done: got idx %0d addr %0d expected idx 32 addr 12", di, da);
        end
        $display("[TB] test_abort done_idx=%0d", di);
    endtask

    task automatic test_stall();
        int di; logic [31:0] da;
        clear_stall();
        stall_pat[9] = 1; stall_pat[10] = 1; stall_pat[11] = 1;
        run_model(2, 1, 1, 2, -1, 0, di, da);
        tests_run++;
        if (di !== 18) begin
            tests_failed++;
            $display("FAIL stall_done: got idx %0d expected 18", di);
        end
        clear_stall();
        $display("[TB] test_stall done_idx=%0d", di);
    endtask

    task automatic test_reset_mid();
        int di; logic [31:0] da;
        logic [111:0] idle_v;
        idle_v = {8'hFF, 8'b1100_0000, 32'd0, 32'd1000, 32'hFFFF_FFFE};
        @(negedge clk);
        p_order = 2; d_order = 1; q_order = 1; num_steps = 2; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (c_ar !== 2'b00 || wren !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_arma: got c_ar %b wren %b expected 00 1", c_ar, wren);
        end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (observed() !== idle_v) begin
                tests_failed++;
                $display("FAIL reset_mid_idle: got %h expected %h", observed(), idle_v);
            end
        end
        clear_stall();
        run_model(2, 1, 1, 2, -1, 0, di, da);
        $display("[TB] test_reset_mid complete");
    endtask

    task automatic test_random();
        int di; logic [31:0] da;
        int unsigned p, d, q, n;
        for (int it = 0; it < 12; it++) begin
            p = $urandom_range(0, 6); d = $urandom_range(0, 6); q = $urandom_range(0, 6);
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) p = 17;
            foreach (stall_pat[i]) stall_pat[i] = ($urandom_range(0, 2) == 0);
            run_model(p, d, q, n, -1, 1, di, da);
            $display("[TB] random it=%0d p=%0d d=%0d q=%0d n=%0d done_idx=%0d", it, p, d, q, n, di);
        end
        clear_stall();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_orders();
        test_cfg_err();
        test_abort();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
